// File: rtl/dram_word_packer_if.sv
// dram_word_packer_if
// Bundles the DRAM read side (access state, data word, valid) together with
// the packed write side (record bus, strobes, addresses, parameter record and
// status flags). The packer uses the slave modport; whoever drives the DRAM
// words and consumes the records uses the master modport.
interface dram_word_packer_if #(
  parameter int DATA_IN_DRAM_WIDTH       = 32,
  parameter int PARAMETERS_WIDTH         = 50,
  parameter int SIG_ADDRS_WIDTH          = 16,
  parameter int INPUT_FEATURE_ADDR_WIDTH = 16,
  parameter int PACK_WIDTH               = 128
) ();

  logic [2:0]                          dram_access_state_i;
  logic [DATA_IN_DRAM_WIDTH-1:0]       dram_data_i;
  logic                                dram_valid_i;

  logic [PACK_WIDTH-1:0]               wr_data_o;
  logic                                weight_wr_en_o;
  logic                                signal_wr_en_o;
  logic                                input_wr_en_o;
  logic [SIG_ADDRS_WIDTH-1:0]          weight_wr_addr_o;
  logic [SIG_ADDRS_WIDTH-1:0]          signal_wr_addr_o;
  logic [INPUT_FEATURE_ADDR_WIDTH-1:0] input_wr_addr_o;
  logic [PARAMETERS_WIDTH-1:0]         parameters_o;
  logic                                param_valid_o;
  logic                                partial_drop_o;
  logic                                overflow_o;

  modport master (
    output dram_access_state_i, dram_data_i, dram_valid_i,
    input  wr_data_o, weight_wr_en_o, signal_wr_en_o, input_wr_en_o,
    input  weight_wr_addr_o, signal_wr_addr_o, input_wr_addr_o,
    input  parameters_o, param_valid_o, partial_drop_o, overflow_o
  );

  modport slave (
    input  dram_access_state_i, dram_data_i, dram_valid_i,
    output wr_data_o, weight_wr_en_o, signal_wr_en_o, input_wr_en_o,
    output weight_wr_addr_o, signal_wr_addr_o, input_wr_addr_o,
    output parameters_o, param_valid_o, partial_drop_o, overflow_o
  );

endinterface

// File: rtl/dram_word_packer.sv
// dram_word_packer
// Collects DRAM read words and packs them, LSB beat first, into parameter,
// weight, signal or input records selected by the controller access state.
// Completed weight/signal/input records leave with a one-cycle strobe and
// the target's own address; the parameter record is held on parameters_o.
// Optional build macro PACKER_BYTE_SWAP_EN byte-reverses every accepted
// DRAM word before it is placed (big-endian DRAM images).
module dram_word_packer #(
  parameter int DATA_IN_DRAM_WIDTH       = 32,
  parameter int PARAMETERS_WIDTH         = 50,
  parameter int ROM_SIG_WIDTH            = 100,
  parameter int N_ROWS_ARRAY             = 16,
  parameter int I_WIDTH                  = 8,
  parameter int F_WIDTH                  = 8,
  parameter int SIG_ADDRS_WIDTH          = 16,
  parameter int INPUT_FEATURE_ADDR_WIDTH = 16,
  parameter int PACK_WIDTH               = 128
) (
  input logic               clk_i,
  input logic               general_rst_n_i,
  dram_word_packer_if.slave bus
);

  localparam int DW         = DATA_IN_DRAM_WIDTH;
  localparam int INPUT_W    = I_WIDTH * N_ROWS_ARRAY;
  localparam int WEIGHT_W   = F_WIDTH * N_ROWS_ARRAY;
  localparam int B_PARAM    = (PARAMETERS_WIDTH + DW - 1) / DW;
  localparam int B_WEIGHT   = (WEIGHT_W + DW - 1) / DW;
  localparam int B_SIGNAL   = (ROM_SIG_WIDTH + DW - 1) / DW;
  localparam int B_INPUT    = (INPUT_W + DW - 1) / DW;
  localparam int PACK_BEATS = (PACK_WIDTH + DW - 1) / DW;
  localparam int ASM_W      = PACK_BEATS * DW;
  localparam int CNT_W      = (PACK_BEATS > 1) ? $clog2(PACK_BEATS) : 1;

  typedef enum logic [2:0] {
    ST_RESET  = 3'b000,
    ST_PARAM  = 3'b001,
    ST_WEIGHT = 3'b010,
    ST_SIGNAL = 3'b011,
    ST_INPUT  = 3'b100,
    ST_FILLED = 3'b101
  } access_state_e;

  function automatic logic [ASM_W-1:0] low_mask(input int width);
    low_mask = {ASM_W{1'b1}} >> (ASM_W - width);
  endfunction

`ifdef PACKER_BYTE_SWAP_EN
  function automatic logic [DW-1:0] swap_bytes(input logic [DW-1:0] word);
    for (int i = 0; i < DW / 8; i++) begin
      swap_bytes[i*8 +: 8] = word[(DW/8 - 1 - i)*8 +: 8];
    end
  endfunction
`endif

  logic [2:0]                          prev_state_q;
  logic [CNT_W-1:0]                    beat_cnt_q, beat_cnt_d;
  logic [ASM_W-1:0]                    asm_q, asm_d;
  logic [PACK_WIDTH-1:0]               wr_data_q, wr_data_d;
  logic                                weight_en_q, weight_en_d;
  logic                                signal_en_q, signal_en_d;
  logic                                input_en_q, input_en_d;
  logic [SIG_ADDRS_WIDTH-1:0]          weight_addr_q, weight_addr_d;
  logic [SIG_ADDRS_WIDTH-1:0]          signal_addr_q, signal_addr_d;
  logic [INPUT_FEATURE_ADDR_WIDTH-1:0] input_addr_q, input_addr_d;
  logic                                weight_sat_q, weight_sat_d;
  logic                                signal_sat_q, signal_sat_d;
  logic                                input_sat_q, input_sat_d;
  logic [PARAMETERS_WIDTH-1:0]         parameters_q, parameters_d;
  logic                                param_valid_q, param_valid_d;
  logic                                partial_drop_q, partial_drop_d;
  logic                                overflow_q, overflow_d;

  logic [DW-1:0]                       placed_word;
  logic                                state_changed;
  logic [CNT_W-1:0]                    beat_base;
  logic [CNT_W-1:0]                    beat_last;
  logic                                accept;
  logic                                complete;
  logic [ASM_W-1:0]                    rec_mask;
  logic [ASM_W-1:0]                    record;
  logic                                weight_blocked;
  logic                                signal_blocked;
  logic                                input_blocked;

`ifdef PACKER_BYTE_SWAP_EN
  assign placed_word = swap_bytes(bus.dram_data_i);
`else
  assign placed_word = bus.dram_data_i;
`endif

  // Beat placement, record completion, strobes, address counters and flags.
  always_comb begin
    state_changed  = (bus.dram_access_state_i != prev_state_q);
    beat_base      = state_changed ? '0 : beat_cnt_q;
    accept         = 1'b0;
    beat_last      = '0;
    rec_mask       = '0;

    case (bus.dram_access_state_i)
      ST_PARAM: begin
        accept    = bus.dram_valid_i;
        beat_last = CNT_W'(B_PARAM - 1);
        rec_mask  = low_mask(PARAMETERS_WIDTH);
      end
      ST_WEIGHT: begin
        accept    = bus.dram_valid_i;
        beat_last = CNT_W'(B_WEIGHT - 1);
        rec_mask  = low_mask(WEIGHT_W);
      end
      ST_SIGNAL: begin
        accept    = bus.dram_valid_i;
        beat_last = CNT_W'(B_SIGNAL - 1);
        rec_mask  = low_mask(ROM_SIG_WIDTH);
      end
      ST_INPUT: begin
        accept    = bus.dram_valid_i;
        beat_last = CNT_W'(B_INPUT - 1);
        rec_mask  = low_mask(INPUT_W);
      end
      default: begin
        accept    = 1'b0;
      end
    endcase

    asm_d = asm_q;
    if (accept) begin
      asm_d[int'(beat_base)*DW +: DW] = placed_word;
    end
    complete = accept && (beat_base == beat_last);
    record   = asm_d & rec_mask;

    if (complete) begin
      beat_cnt_d = '0;
    end else if (accept) begin
      beat_cnt_d = beat_base + CNT_W'(1);
    end else begin
      beat_cnt_d = beat_base;
    end

    // A strobe at the all-ones address is the last write that target gets.
    weight_blocked = weight_sat_q || (weight_en_q && (&weight_addr_q));
    signal_blocked = signal_sat_q || (signal_en_q && (&signal_addr_q));
    input_blocked  = input_sat_q  || (input_en_q  && (&input_addr_q));

    weight_en_d    = 1'b0;
    signal_en_d    = 1'b0;
    input_en_d     = 1'b0;
    wr_data_d      = wr_data_q;
    parameters_d   = parameters_q;
    param_valid_d  = param_valid_q;
    overflow_d     = overflow_q;
    partial_drop_d = partial_drop_q || (state_changed && (beat_cnt_q != '0));

    weight_addr_d  = weight_addr_q;
    signal_addr_d  = signal_addr_q;
    input_addr_d   = input_addr_q;
    weight_sat_d   = weight_blocked;
    signal_sat_d   = signal_blocked;
    input_sat_d    = input_blocked;

    if (weight_en_q && !(&weight_addr_q)) begin
      weight_addr_d = weight_addr_q + SIG_ADDRS_WIDTH'(1);
    end
    if (signal_en_q && !(&signal_addr_q)) begin
      signal_addr_d = signal_addr_q + SIG_ADDRS_WIDTH'(1);
    end
    if (input_en_q && !(&input_addr_q)) begin
      input_addr_d = input_addr_q + INPUT_FEATURE_ADDR_WIDTH'(1);
    end

    if (complete) begin
      case (bus.dram_access_state_i)
        ST_PARAM: begin
          parameters_d  = record[PARAMETERS_WIDTH-1:0];
          param_valid_d = 1'b1;
        end
        ST_WEIGHT: begin
          if (weight_blocked) begin
            overflow_d  = 1'b1;
          end else begin
            weight_en_d = 1'b1;
            wr_data_d   = record[PACK_WIDTH-1:0];
          end
        end
        ST_SIGNAL: begin
          if (signal_blocked) begin
            overflow_d  = 1'b1;
          end else begin
            signal_en_d = 1'b1;
            wr_data_d   = record[PACK_WIDTH-1:0];
          end
        end
        ST_INPUT: begin
          if (input_blocked) begin
            overflow_d = 1'b1;
          end else begin
            input_en_d = 1'b1;
            wr_data_d  = record[PACK_WIDTH-1:0];
          end
        end
        default: begin
          overflow_d = overflow_q;
        end
      endcase
    end

    // The controller's reset state rearms every target but keeps the
    // last parameter record visible.
    if (bus.dram_access_state_i == ST_RESET) begin
      weight_addr_d  = '0;
      signal_addr_d  = '0;
      input_addr_d   = '0;
      weight_sat_d   = 1'b0;
      signal_sat_d   = 1'b0;
      input_sat_d    = 1'b0;
      param_valid_d  = 1'b0;
      partial_drop_d = 1'b0;
      overflow_d     = 1'b0;
    end
  end

  // State register for the packer; everything returns to zero on reset.
  always_ff @(posedge clk_i or negedge general_rst_n_i) begin
    if (!general_rst_n_i) begin
      prev_state_q   <= ST_RESET;
      beat_cnt_q     <= '0;
      asm_q          <= '0;
      wr_data_q      <= '0;
      weight_en_q    <= 1'b0;
      signal_en_q    <= 1'b0;
      input_en_q     <= 1'b0;
      weight_addr_q  <= '0;
      signal_addr_q  <= '0;
      input_addr_q   <= '0;
      weight_sat_q   <= 1'b0;
      signal_sat_q   <= 1'b0;
      input_sat_q    <= 1'b0;
      parameters_q   <= '0;
      param_valid_q  <= 1'b0;
      partial_drop_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      prev_state_q   <= bus.dram_access_state_i;
      beat_cnt_q     <= beat_cnt_d;
      asm_q          <= asm_d;
      wr_data_q      <= wr_data_d;
      weight_en_q    <= weight_en_d;
      signal_en_q    <= signal_en_d;
      input_en_q     <= input_en_d;
      weight_addr_q  <= weight_addr_d;
      signal_addr_q  <= signal_addr_d;
      input_addr_q   <= input_addr_d;
      weight_sat_q   <= weight_sat_d;
      signal_sat_q   <= signal_sat_d;
      input_sat_q    <= input_sat_d;
      parameters_q   <= parameters_d;
      param_valid_q  <= param_valid_d;
      partial_drop_q <= partial_drop_d;
      overflow_q     <= overflow_d;
    end
  end

  assign bus.wr_data_o        = wr_data_q;
  assign bus.weight_wr_en_o   = weight_en_q;
  assign bus.signal_wr_en_o   = signal_en_q;
  assign bus.input_wr_en_o    = input_en_q;
  assign bus.weight_wr_addr_o = weight_addr_q;
  assign bus.signal_wr_addr_o = signal_addr_q;
  assign bus.input_wr_addr_o  = input_addr_q;
  assign bus.parameters_o     = parameters_q;
  assign bus.param_valid_o    = param_valid_q;
  assign bus.partial_drop_o   = partial_drop_q;
  assign bus.overflow_o       = overflow_q;

endmodule

// File: tb/tb_dram_word_packer.sv
// tb_dram_word_packer
// Directed bench for dram_word_packer. A default-parameter instance covers
// parameters, weights, signals, inputs, dropped partial records and async
// reset; a second instance with 2-bit weight/signal addresses covers address
// saturation. Expected records are queued when their beats are driven and
// popped by per-instance monitors whenever a write strobe appears.
// Honours PACKER_BYTE_SWAP_EN in the reference model.
module tb_dram_word_packer;

  typedef struct packed {
    logic [1:0]   kind;
    logic [127:0] data;
    logic [15:0]  addr;
  } exp_t;

  localparam logic [1:0] K_WEIGHT = 2'd0;
  localparam logic [1:0] K_SIGNAL = 2'd1;
  localparam logic [1:0] K_INPUT  = 2'd2;

  logic clk_i = 1'b0;
  logic general_rst_n_i;

  int vectors     = 0;
  int miscompares = 0;

  exp_t exp_main[$];
  exp_t exp_sat[$];

  logic [127:0] rec;
  logic [127:0] param_rec;

  logic [2:0]   seen_main;
  logic [2:0]   seen_sat;
  exp_t         e_main;
  exp_t         e_sat;
  logic [15:0]  addr_main;
  logic [15:0]  addr_sat;

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  dram_word_packer_if bus ();
  dram_word_packer_if #(.SIG_ADDRS_WIDTH(2)) sat_bus ();

  dram_word_packer dut (
    .clk_i          (clk_i),
    .general_rst_n_i(general_rst_n_i),
    .bus            (bus)
  );

  dram_word_packer #(.SIG_ADDRS_WIDTH(2)) dut_sat (
    .clk_i          (clk_i),
    .general_rst_n_i(general_rst_n_i),
    .bus            (sat_bus)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelWord(input logic [31:0] w);
`ifdef PACKER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [2:0] kindOneHot(input logic [1:0] kind);
    case (kind)
      K_WEIGHT: return 3'b100;
      K_SIGNAL: return 3'b010;
      default:  return 3'b001;
    endcase
  endfunction

  // Drive one cycle of DRAM inputs on either instance, then step to
  // just after the sampling edge.
  task automatic applyStimulus(input bit sel, input logic [2:0] st,
                               input logic [31:0] data, input logic valid);
    if (sel) begin
      sat_bus.dram_access_state_i = st;
      sat_bus.dram_data_i         = data;
      sat_bus.dram_valid_i        = valid;
    end else begin
      bus.dram_access_state_i = st;
      bus.dram_data_i         = data;
      bus.dram_valid_i        = valid;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Build the expected record from its beats, optionally queue it, then
  // drive the beats on consecutive cycles.
  task automatic sendRecord(input bit sel, input logic [2:0] st,
                            input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3,
                            input int nbeats, input int width, input bit push,
                            input logic [1:0] kind, input logic [15:0] addr,
                            output logic [127:0] rec_out);
    logic [31:0] beats [4];
    exp_t        e;
    beats   = '{b0, b1, b2, b3};
    rec_out = '0;
    for (int k = 0; k < nbeats; k++) rec_out[k*32 +: 32] = modelWord(beats[k]);
    for (int i = width; i < 128; i++) rec_out[i] = 1'b0;
    if (push) begin
      e.kind = kind;
      e.data = rec_out;
      e.addr = addr;
      if (sel) exp_sat.push_back(e);
      else     exp_main.push_back(e);
    end
    for (int k = 0; k < nbeats; k++) applyStimulus(sel, st, beats[k], 1'b1);
  endtask

  // Scoreboard for the default instance: every strobe must match the
  // oldest queued record.
  always @(negedge clk_i) begin
    if (general_rst_n_i) begin
      seen_main = {bus.weight_wr_en_o, bus.signal_wr_en_o, bus.input_wr_en_o};
      if (seen_main != 3'b000) begin
        if (exp_main.size() == 0) begin
          checkOutput("unexpected_strobe", 128'(seen_main), 128'd0);
        end else begin
          e_main = exp_main.pop_front();
          case (e_main.kind)
            K_WEIGHT: addr_main = bus.weight_wr_addr_o;
            K_SIGNAL: addr_main = bus.signal_wr_addr_o;
            default:  addr_main = bus.input_wr_addr_o;
          endcase
          checkOutput("strobe_kind", 128'(seen_main), 128'(kindOneHot(e_main.kind)));
          checkOutput("wr_data", bus.wr_data_o, e_main.data);
          checkOutput("wr_addr", 128'(addr_main), 128'(e_main.addr));
        end
      end
    end
  end

  // Scoreboard for the narrow-address instance.
  always @(negedge clk_i) begin
    if (general_rst_n_i) begin
      seen_sat = {sat_bus.weight_wr_en_o, sat_bus.signal_wr_en_o, sat_bus.input_wr_en_o};
      if (seen_sat != 3'b000) begin
        if (exp_sat.size() == 0) begin
          checkOutput("sat_unexpected_strobe", 128'(seen_sat), 128'd0);
        end else begin
          e_sat = exp_sat.pop_front();
          case (e_sat.kind)
            K_WEIGHT: addr_sat = 16'(sat_bus.weight_wr_addr_o);
            K_SIGNAL: addr_sat = 16'(sat_bus.signal_wr_addr_o);
            default:  addr_sat = sat_bus.input_wr_addr_o;
          endcase
          checkOutput("sat_strobe_kind", 128'(seen_sat), 128'(kindOneHot(e_sat.kind)));
          checkOutput("sat_wr_data", sat_bus.wr_data_o, e_sat.data);
          checkOutput("sat_wr_addr", 128'(addr_sat), 128'(e_sat.addr));
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    general_rst_n_i             = 1'b0;
    bus.dram_access_state_i     = 3'b000;
    bus.dram_data_i             = '0;
    bus.dram_valid_i            = 1'b0;
    sat_bus.dram_access_state_i = 3'b000;
    sat_bus.dram_data_i         = '0;
    sat_bus.dram_valid_i        = 1'b0;
    #12;

    $display("[TB] reset values");
    checkOutput("rst_wr_data", bus.wr_data_o, 128'd0);
    checkOutput("rst_strobes", 128'({bus.weight_wr_en_o, bus.signal_wr_en_o, bus.input_wr_en_o}), 128'd0);
    checkOutput("rst_addrs", 128'({bus.weight_wr_addr_o, bus.signal_wr_addr_o, bus.input_wr_addr_o}), 128'd0);
    checkOutput("rst_params", 128'(bus.parameters_o), 128'd0);
    checkOutput("rst_flags", 128'({bus.param_valid_o, bus.partial_drop_o, bus.overflow_o}), 128'd0);
    general_rst_n_i = 1'b1;
    applyStimulus(1'b0, 3'b000, 32'h0, 1'b0);

    $display("[TB] parameter record");
    sendRecord(1'b0, 3'b001, 32'h11111111, 32'h00000003, 32'h0, 32'h0,
               2, 50, 1'b0, K_WEIGHT, 16'd0, param_rec);
    checkOutput("param_value", 128'(bus.parameters_o), param_rec);
    checkOutput("param_valid", 128'(bus.param_valid_o), 128'd1);

    $display("[TB] weight records");
    sendRecord(1'b0, 3'b010, 32'hA0, 32'hA1, 32'hA2, 32'hA3,
               4, 128, 1'b1, K_WEIGHT, 16'd0, rec);
    sendRecord(1'b0, 3'b010, 32'hB0B0B0B0, 32'h12345678, 32'h0, 32'hDEADBEEF,
               4, 128, 1'b1, K_WEIGHT, 16'd1, rec);
    applyStimulus(1'b0, 3'b010, 32'h0, 1'b0);
    checkOutput("weight_addr_after", 128'(bus.weight_wr_addr_o), 128'd2);
    checkOutput("wr_data_hold", bus.wr_data_o, rec);

    $display("[TB] signal record");
    sendRecord(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               4, 100, 1'b1, K_SIGNAL, 16'd0, rec);
    applyStimulus(1'b0, 3'b011, 32'h0, 1'b0);
    checkOutput("signal_addr_after", 128'(bus.signal_wr_addr_o), 128'd1);

    $display("[TB] partial record dropped");
    applyStimulus(1'b0, 3'b100, 32'h01, 1'b1);
    applyStimulus(1'b0, 3'b100, 32'h02, 1'b1);
    checkOutput("no_drop_yet", 128'(bus.partial_drop_o), 128'd0);
    applyStimulus(1'b0, 3'b101, 32'h03, 1'b1);
    checkOutput("partial_drop", 128'(bus.partial_drop_o), 128'd1);
    applyStimulus(1'b0, 3'b101, 32'h04, 1'b1);
    applyStimulus(1'b0, 3'b000, 32'h0, 1'b0);
    checkOutput("drop_cleared", 128'(bus.partial_drop_o), 128'd0);
    checkOutput("addrs_cleared", 128'({bus.weight_wr_addr_o, bus.signal_wr_addr_o, bus.input_wr_addr_o}), 128'd0);
    checkOutput("param_valid_cleared", 128'(bus.param_valid_o), 128'd0);
    checkOutput("params_kept", 128'(bus.parameters_o), param_rec);

    $display("[TB] input record then async reset mid-record");
    sendRecord(1'b0, 3'b100, 32'hC0, 32'hC1, 32'hC2, 32'hC3,
               4, 128, 1'b1, K_INPUT, 16'd0, rec);
    applyStimulus(1'b0, 3'b100, 32'h0, 1'b0);
    checkOutput("input_addr_after", 128'(bus.input_wr_addr_o), 128'd1);
    applyStimulus(1'b0, 3'b100, 32'hD0, 1'b1);
    applyStimulus(1'b0, 3'b100, 32'hD1, 1'b1);
    #2;
    general_rst_n_i = 1'b0;
    #1;
    checkOutput("async_wr_data", bus.wr_data_o, 128'd0);
    checkOutput("async_input_addr", 128'(bus.input_wr_addr_o), 128'd0);
    checkOutput("async_params", 128'(bus.parameters_o), 128'd0);
    checkOutput("async_strobes", 128'({bus.weight_wr_en_o, bus.signal_wr_en_o, bus.input_wr_en_o}), 128'd0);
    @(posedge clk_i);
    #1;
    general_rst_n_i = 1'b1;
    sendRecord(1'b0, 3'b100, 32'hE0, 32'hE1, 32'hE2, 32'hE3,
               4, 128, 1'b1, K_INPUT, 16'd0, rec);
    applyStimulus(1'b0, 3'b100, 32'h0, 1'b0);
    checkOutput("resume_input_addr", 128'(bus.input_wr_addr_o), 128'd1);

    $display("[TB] weight address saturation");
    for (int r = 0; r < 5; r++) begin
      sendRecord(1'b1, 3'b010, 32'h100 + 32'(r), 32'h200 + 32'(r),
                 32'h300 + 32'(r), 32'h400 + 32'(r),
                 4, 128, (r < 4), K_WEIGHT, 16'(r), rec);
      if (r == 3) checkOutput("sat_no_overflow_yet", 128'(sat_bus.overflow_o), 128'd0);
    end
    checkOutput("sat_overflow", 128'(sat_bus.overflow_o), 128'd1);
    applyStimulus(1'b1, 3'b010, 32'h0, 1'b0);
    applyStimulus(1'b1, 3'b010, 32'h0, 1'b0);
    checkOutput("sat_addr_held", 128'(sat_bus.weight_wr_addr_o), 128'd3);
    checkOutput("sat_overflow_sticky", 128'(sat_bus.overflow_o), 128'd1);

    applyStimulus(1'b1, 3'b000, 32'h0, 1'b0);
    checkOutput("sat_overflow_cleared", 128'(sat_bus.overflow_o), 128'd0);
    checkOutput("pending_main", 128'(exp_main.size()), 128'd0);
    checkOutput("pending_sat", 128'(exp_sat.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
